// File: rtl/uart_core_cfg.sv
// Configurable full-duplex UART: TX and RX shift engines, each fronted by a
// first-word fall-through FIFO, with sticky receive-overrun reporting.
module uart_core_cfg #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        uart_rx,
    output logic                        uart_tx,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] tx_count,
    output logic [7:0]                  rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        rx_parity_err,
    output logic                        rx_frame_err,
    output logic [$clog2(FIFO_DEPTH):0] rx_count,
    output logic                        rx_overrun,
    input  logic                        ovr_clr
);

    localparam int unsigned CPB   = CLK_FREQ / BAUD_RATE;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned CNT_W = $clog2(STOP_BITS * CPB + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CPB - 1);
    localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [2:0]       DB_LAST   = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // ---------------- TX FIFO ----------------
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr_ptr, tx_rd_ptr;
    logic                 tx_push, tx_pop;

    assign tx_ready = (tx_count != DEPTH_C);
    assign tx_push  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= tx_data[DATA_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            tx_count  <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
            tx_count <= tx_count + CW'(tx_push) - CW'(tx_pop);
        end
    end

    // ---------------- TX FSM ----------------
    state_t               tx_state, tx_state_n;
    logic [CNT_W-1:0]     tx_cnt, tx_cnt_n;
    logic [2:0]           tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_shr, tx_shr_n;
    logic                 tx_line_n, tx_par_bit;

    assign tx_par_bit = (^tx_shr) ^ (PARITY == 1);
    assign tx_busy    = (tx_state != S_IDLE) || (tx_count != '0);

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 1'b1;
        tx_idx_n   = tx_idx;
        tx_shr_n   = tx_shr;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (tx_count != '0) begin
                    tx_pop     = 1'b1;
                    tx_shr_n   = tx_mem[tx_rd_ptr];
                    tx_state_n = S_START;
                end
            end
            S_START: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_state_n = S_DATA;
            end
            S_DATA: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n = '0;
                if (tx_idx == DB_LAST)
                    tx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                    tx_idx_n = tx_idx + 3'd1;
            end
            S_PARITY: if (tx_cnt == BIT_LAST) begin
                tx_cnt_n   = '0;
                tx_state_n = S_STOP;
            end
            S_STOP: if (tx_cnt == STOP_LAST) begin
                // Chain straight into the next start bit so frames abut.
                tx_cnt_n = '0;
                if (tx_count != '0) begin
                    tx_pop     = 1'b1;
                    tx_shr_n   = tx_mem[tx_rd_ptr];
                    tx_state_n = S_START;
                end else begin
                    tx_state_n = S_IDLE;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase

        tx_line_n = 1'b1;
        case (tx_state_n)
            S_START:  tx_line_n = 1'b0;
            S_DATA:   tx_line_n = tx_shr_n[tx_idx_n];
            S_PARITY: tx_line_n = tx_par_bit;
            default:  tx_line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shr   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_shr   <= tx_shr_n;
            uart_tx  <= tx_line_n;
        end
    end

    // ---------------- RX synchronizer and FSM ----------------
    logic rx_s1, rx_s2, rx_prev, rx_fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    state_t               rx_state, rx_state_n;
    logic [CNT_W-1:0]     rx_cnt, rx_cnt_n;
    logic [2:0]           rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_shr, rx_shr_n;
    logic                 rx_perr, rx_perr_n, rx_par_exp, rx_done;
    logic                 rx_wr_pend;
    logic [DATA_BITS+1:0] rx_wr_word;

    assign rx_par_exp = (^rx_shr) ^ (PARITY == 1);

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 1'b1;
        rx_idx_n   = rx_idx;
        rx_shr_n   = rx_shr;
        rx_perr_n  = rx_perr;
        rx_done    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                if (rx_fall) rx_state_n = S_START;
            end
            S_START: if (rx_cnt == HALF_LAST) begin
                rx_cnt_n = '0;
                if (rx_s2) begin
                    rx_state_n = S_IDLE;
                end else begin
                    rx_state_n = S_DATA;
                    rx_idx_n   = '0;
                    rx_perr_n  = 1'b0;
                end
            end
            S_DATA: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n         = '0;
                rx_shr_n[rx_idx] = rx_s2;
                if (rx_idx == DB_LAST)
                    rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                else
                    rx_idx_n = rx_idx + 3'd1;
            end
            S_PARITY: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_perr_n  = rx_s2 ^ rx_par_exp;
                rx_state_n = S_STOP;
            end
            S_STOP: if (rx_cnt == BIT_LAST) begin
                rx_cnt_n   = '0;
                rx_done    = 1'b1;
                rx_state_n = S_IDLE;
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= S_IDLE;
            rx_cnt     <= '0;
            rx_idx     <= '0;
            rx_shr     <= '0;
            rx_perr    <= 1'b0;
            rx_wr_pend <= 1'b0;
            rx_wr_word <= '0;
        end else begin
            rx_state   <= rx_state_n;
            rx_cnt     <= rx_cnt_n;
            rx_idx     <= rx_idx_n;
            rx_shr     <= rx_shr_n;
            rx_perr    <= rx_perr_n;
            rx_wr_pend <= rx_done;
            if (rx_done)
                rx_wr_word <= {rx_perr, ~rx_s2, rx_shr};
        end
    end

    // ---------------- RX FIFO ----------------
    logic [DATA_BITS+1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr_ptr, rx_rd_ptr;
    logic [DATA_BITS+1:0] rx_head;
    logic                 rx_push, rx_pop, rx_full, ovr_set;

    assign rx_full  = (rx_count == DEPTH_C);
    assign rx_valid = (rx_count != '0);
    assign rx_pop   = rx_valid && rx_ready;
    assign rx_push  = rx_wr_pend && (!rx_full || rx_pop);
    assign ovr_set  = rx_wr_pend && rx_full && !rx_pop;
    assign rx_head  = rx_mem[rx_rd_ptr];

    // Head fields are masked while empty so stale entries never show.
    assign rx_data       = rx_valid ? 8'(rx_head[DATA_BITS-1:0]) : '0;
    assign rx_frame_err  = rx_valid & rx_head[DATA_BITS];
    assign rx_parity_err = rx_valid & rx_head[DATA_BITS+1];

    always_ff @(posedge clk) begin
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_wr_ptr  <= '0;
            rx_rd_ptr  <= '0;
            rx_count   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
            rx_count <= rx_count + CW'(rx_push) - CW'(rx_pop);
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (ovr_clr)
                rx_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_core_cfg.sv
// Self-checking bench: an 8N1 instance (loopback-capable) and a 7E2 instance,
// both depth 4 at 10 clocks per bit, checked against a frame-level model.
module tb_uart_core_cfg;

    localparam int CPB = 10;

    typedef bit bq_t[$];
    typedef logic [7:0] byteq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: 8N1
    logic       a_rx_drv = 1'b1, a_loop = 1'b0, a_uart_rx, a_uart_tx;
    logic [7:0] a_tx_data = '0, a_rx_data;
    logic       a_tx_valid = 1'b0, a_tx_ready, a_tx_busy;
    logic [2:0] a_tx_count, a_rx_count;
    logic       a_rx_valid, a_rx_ready = 1'b0, a_rx_perr, a_rx_ferr, a_rx_overrun;
    logic       a_ovr_clr = 1'b0;

    assign a_uart_rx = a_loop ? a_uart_tx : a_rx_drv;

    // Instance B: 7 data bits, even parity, 2 stop bits
    logic       b_rx_drv = 1'b1, b_uart_tx;
    logic [7:0] b_tx_data = '0, b_rx_data;
    logic       b_tx_valid = 1'b0, b_tx_ready, b_tx_busy;
    logic [2:0] b_tx_count, b_rx_count;
    logic       b_rx_valid, b_rx_ready = 1'b0, b_rx_perr, b_rx_ferr, b_rx_overrun;
    logic       b_ovr_clr = 1'b0;

    uart_core_cfg #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst), .uart_rx(a_uart_rx), .uart_tx(a_uart_tx),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready),
        .tx_busy(a_tx_busy), .tx_count(a_tx_count), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_parity_err(a_rx_perr),
        .rx_frame_err(a_rx_ferr), .rx_count(a_rx_count), .rx_overrun(a_rx_overrun),
        .ovr_clr(a_ovr_clr)
    );

    uart_core_cfg #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst), .uart_rx(b_rx_drv), .uart_tx(b_uart_tx),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready),
        .tx_busy(b_tx_busy), .tx_count(b_tx_count), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_parity_err(b_rx_perr),
        .rx_frame_err(b_rx_ferr), .rx_count(b_rx_count), .rx_overrun(b_rx_overrun),
        .ovr_clr(b_ovr_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-level frame model: start, data LSB first, optional parity, stops.
    function automatic bq_t frame_bits(input logic [7:0] data, input int nbits, input int par,
                                       input int stops, input bit flip, input bit bad_stop);
        bq_t q;
        int  ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) begin
            q.push_back(data[i]);
            if (data[i]) ones++;
        end
        if (par != 0)
            q.push_back(((ones % 2) == 1) ^ (par == 1) ^ flip);
        q.push_back(!bad_stop);
        for (int s = 1; s < stops; s++) q.push_back(1'b1);
        return q;
    endfunction

    task automatic send_serial(input bit to_b, input bq_t q);
        foreach (q[i]) begin
            for (int c = 0; c < CPB; c++) begin
                if (to_b) b_rx_drv = q[i]; else a_rx_drv = q[i];
                @(negedge clk);
            end
        end
        if (to_b) b_rx_drv = 1'b1; else a_rx_drv = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic pop_rx(input bit to_b);
        if (to_b) b_rx_ready = 1'b1; else a_rx_ready = 1'b1;
        @(negedge clk);
        a_rx_ready = 1'b0;
        b_rx_ready = 1'b0;
    endtask

    // Watches A's line cycle by cycle against the model for a run of abutting frames.
    task automatic expect_tx(input byteq_t bytes, input string tag);
        int         n = 0;
        int         bad;
        logic [7:0] dec;
        bq_t        q;
        while (a_uart_tx !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (a_uart_tx !== 1'b0) begin
            check({tag, " start timeout"}, 32'(a_uart_tx), 32'd0);
            return;
        end
        foreach (bytes[k]) begin
            q   = frame_bits(bytes[k], 8, 0, 1, 1'b0, 1'b0);
            bad = 0;
            dec = '0;
            foreach (q[i]) begin
                for (int c = 0; c < CPB; c++) begin
                    if (a_uart_tx !== q[i]) bad++;
                    if (c == CPB / 2 && i >= 1 && i <= 8) dec[i-1] = a_uart_tx;
                    @(negedge clk);
                end
            end
            check($sformatf("%s frame%0d cycle errs", tag, k), 32'(bad), 32'd0);
            check($sformatf("%s frame%0d byte", tag, k), 32'(dec), 32'(bytes[k]));
        end
        check({tag, " busy after"}, 32'(a_tx_busy), 32'd0);
        check({tag, " idle line"}, 32'(a_uart_tx), 32'd1);
    endtask

    typedef struct {
        bit         to_b;
        logic [7:0] data;
        bit         flip;
        bit         bad_stop;
        logic [7:0] exp_data;
        bit         exp_perr;
        bit         exp_ferr;
    } rxvec_t;

    rxvec_t vecs [8];
    bit     mon_done;

    initial begin
        byteq_t     bl;
        bq_t        q;
        logic [7:0] exp_q[$];
        int         n, sent;

        vecs[0] = '{1'b1, 8'h35, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h35, 1'b1, 1'b0, 8'h35, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 8'h7F, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'hB5, 1'b0, 1'b0, 8'h35, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst a uart_tx", 32'(a_uart_tx), 32'd1);
        check("rst a tx_ready", 32'(a_tx_ready), 32'd1);
        check("rst a tx_busy", 32'(a_tx_busy), 32'd0);
        check("rst a counts", 32'({a_tx_count, a_rx_count}), 32'd0);
        check("rst a rx_valid", 32'(a_rx_valid), 32'd0);
        check("rst a rx_data", 32'(a_rx_data), 32'd0);
        check("rst a flags", 32'({a_rx_overrun, a_rx_perr, a_rx_ferr}), 32'd0);
        check("rst b uart_tx", 32'(b_uart_tx), 32'd1);
        check("rst b state", 32'({b_tx_ready, b_tx_busy, b_rx_valid}), 32'b100);
        check("rst b counts", 32'({b_tx_count, b_rx_count}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 8N1 waveform for 0xA5
        a_tx_data  = 8'hA5;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        bl = '{8'hA5};
        expect_tx(bl, "a5");

        // Table-driven receive vectors
        foreach (vecs[v]) begin
            q = frame_bits(vecs[v].data, vecs[v].to_b ? 7 : 8, vecs[v].to_b ? 2 : 0,
                           vecs[v].to_b ? 2 : 1, vecs[v].flip, vecs[v].bad_stop);
            send_serial(vecs[v].to_b, q);
            check($sformatf("vec%0d valid", v),
                  32'(vecs[v].to_b ? b_rx_valid : a_rx_valid), 32'd1);
            check($sformatf("vec%0d data", v),
                  32'(vecs[v].to_b ? b_rx_data : a_rx_data), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d perr", v),
                  32'(vecs[v].to_b ? b_rx_perr : a_rx_perr), 32'(vecs[v].exp_perr));
            check($sformatf("vec%0d ferr", v),
                  32'(vecs[v].to_b ? b_rx_ferr : a_rx_ferr), 32'(vecs[v].exp_ferr));
            pop_rx(vecs[v].to_b);
            check($sformatf("vec%0d empty after pop", v),
                  32'(vecs[v].to_b ? b_rx_valid : a_rx_valid), 32'd0);
        end

        // Overrun: 5 frames into a 4-deep RX FIFO with no pops
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        foreach (exp_q[k]) send_serial(1'b0, frame_bits(exp_q[k], 8, 0, 1, 1'b0, 1'b0));
        check("ovr rx_count", 32'(a_rx_count), 32'd4);
        check("ovr flag set", 32'(a_rx_overrun), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ovr pop%0d", k), 32'(a_rx_data), 32'(exp_q[k]));
            pop_rx(1'b0);
        end
        check("ovr drained", 32'(a_rx_valid), 32'd0);
        check("ovr still sticky", 32'(a_rx_overrun), 32'd1);
        a_ovr_clr = 1'b1;
        @(negedge clk);
        a_ovr_clr = 1'b0;
        check("ovr cleared", 32'(a_rx_overrun), 32'd0);

        // Back-to-back TX with a 4-deep FIFO; pushes while full are ignored
        bl = '{8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E};
        mon_done = 1'b0;
        fork
            begin
                expect_tx(bl, "b2b");
                mon_done = 1'b1;
            end
        join_none
        a_tx_valid = 1'b1;
        foreach (bl[k]) begin
            a_tx_data = bl[k];
            n = 0;
            while (!a_tx_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
        end
        a_tx_valid = 1'b0;
        check("b2b count full", 32'(a_tx_count), 32'd4);
        check("b2b ready low", 32'(a_tx_ready), 32'd0);
        a_tx_data  = 8'hEE;
        a_tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        a_tx_valid = 1'b0;
        check("b2b push ignored", 32'(a_tx_count), 32'd4);
        n = 0;
        while (!mon_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b monitor done", 32'(mon_done), 32'd1);

        // Reset in the middle of data bit 3, loopback so RX is mid-frame too
        a_loop     = 1'b1;
        a_tx_data  = 8'hC3;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        n = 0;
        while (a_uart_tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (45) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst uart_tx", 32'(a_uart_tx), 32'd1);
        check("midrst counts", 32'({a_tx_count, a_rx_count}), 32'd0);
        check("midrst busy", 32'(a_tx_busy), 32'd0);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("midrst rx discarded", 32'(a_rx_count), 32'd0);
        a_tx_data  = 8'h5A;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        n = 0;
        while (!a_rx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("post-rst loop data", 32'({a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_data}),
              32'({3'b100, 8'h5A}));
        pop_rx(1'b0);

        // Short low glitch must be rejected as a false start
        a_loop   = 1'b0;
        a_rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        a_rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch no entry", 32'(a_rx_count), 32'd0);

        // Randomized loopback traffic against a byte scoreboard
        a_loop = 1'b1;
        sent   = 0;
        exp_q  = {};
        for (int cyc = 0; cyc < 8000 && (sent < 24 || exp_q.size() > 0); cyc++) begin
            a_rx_ready = 1'($urandom_range(0, 1));
            if (a_rx_ready && a_rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("rand unexpected rx", 32'(a_rx_data), 32'hFFFF_FFFF);
                end else begin
                    check("rand rx byte", 32'({a_rx_perr, a_rx_ferr, a_rx_data}),
                          32'(exp_q.pop_front()));
                end
            end
            a_tx_valid = (sent < 24) && ($urandom_range(0, 3) == 0);
            a_tx_data  = 8'($urandom);
            if (a_tx_valid && a_tx_ready) begin
                exp_q.push_back(a_tx_data);
                sent++;
            end
            @(negedge clk);
        end
        a_tx_valid = 1'b0;
        a_rx_ready = 1'b0;
        check("rand all sent", 32'(sent), 32'd24);
        check("rand all received", 32'(exp_q.size()), 32'd0);
        check("rand no overrun", 32'(a_rx_overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_core_cfg.md
UART_CORE_CFG -- requirements
Module: uart_core_cfg

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_FREQ, 100_000_000, clock frequency in Hz
- BAUD_RATE, 115200, line rate; CPB = CLK_FREQ/BAUD_RATE clocks per bit, integer-truncated, CPB >= 4
- DATA_BITS, 8, data bits per frame, legal range 5..8
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, entries per FIFO, power of 2, >= 2; CW = $clog2(FIFO_DEPTH)+1
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- uart_rx  in  1  serial input, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- tx_data  in  8  byte to send; bits above DATA_BITS-1 ignored
- tx_valid  in  1  push request into TX FIFO
- tx_ready  out  1  TX FIFO not full
- tx_busy  out  1  frame in progress or TX FIFO non-empty
- tx_count  out  CW  TX FIFO occupancy
- rx_data  out  8  head of RX FIFO; bits above DATA_BITS-1 read 0
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  pop request
- rx_parity_err  out  1  parity error flag of the head entry
- rx_frame_err  out  1  stop-bit error flag of the head entry
- rx_count  out  CW  RX FIFO occupancy
- rx_overrun  out  1  sticky flag: a frame was dropped because the RX FIFO was full
- ovr_clr  in  1  clears rx_overrun

Function
REQ-003 A push SHALL occur when tx_valid && tx_ready; tx_valid while full SHALL be ignored with no state change.
REQ-004 A pop SHALL occur when rx_valid && rx_ready; rx_ready while empty SHALL be ignored.
REQ-005 FIFOs SHALL be first-word fall-through: head data valid in the cycle rx_valid is high, registered outputs, pointer wrap modulo FIFO_DEPTH.
REQ-006 Simultaneous push and pop on the same FIFO SHALL leave the count unchanged, including when full (RX) or empty.
REQ-007 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; each bit SHALL be held for exactly CPB cycles.
REQ-008 In IDLE with TX FIFO non-empty, the FSM SHALL pop one entry and drive the start bit (0) on the next cycle; the data bits SHALL follow LSB first.
REQ-009 PARITY SHALL be skipped when PARITY=0; otherwise the bit SHALL be the XOR of the data bits (even) or its inverse (odd).
REQ-010 STOP SHALL drive 1 for STOP_BITS*CPB cycles; back-to-back frames SHALL have no extra idle gap.
REQ-011 uart_rx SHALL pass through a 2-flop synchronizer before use.
REQ-012 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 A synchronized falling edge SHALL move the RX FSM from IDLE to START; the line SHALL be resampled at CPB/2.
- High at that sample: false start, return to IDLE.
- Low: later bits sampled every CPB cycles (mid-bit).
REQ-014 Only the first stop bit SHALL be checked; a 0 there SHALL set the entry's frame_err.
REQ-015 A parity mismatch SHALL set the entry's parity_err.
REQ-016 A frame SHALL be written to the RX FIFO even when it carries errors.
REQ-017 After the stop sample, the RX FSM SHALL return to IDLE and re-arm on the next falling edge.
REQ-018 The RX FIFO write SHALL occur in the cycle after the stop-bit sample; if the FIFO is full and no pop occurs that cycle, the frame SHALL be discarded and rx_overrun set.
REQ-019 ovr_clr SHALL clear rx_overrun unless a new overrun occurs in the same cycle; the overrun set SHALL win.
REQ-020 TX and RX SHALL operate fully independently (full duplex).

Reset
REQ-021 While rst is high at a clk edge, the block SHALL take its reset state:
- uart_tx = 1
- both FSMs in IDLE
- FIFOs empty; counts = 0
- tx_ready = 1, tx_busy = 0, rx_valid = 0
- rx_overrun, rx_parity_err and rx_frame_err = 0
- rx_data = 0
REQ-022 Reset mid-frame SHALL abort the frame: uart_tx = 1 from the cycle after the reset edge, and partial RX data SHALL be discarded.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, CPB=10 unless noted)
REQ-023 8N1, push 0xA5 -> uart_tx from first low cycle: 0, 1,0,1,0,0,1,0,1, 1, each 10 cycles; tx_busy falls after the stop bit.
REQ-024 PARITY=2, DATA_BITS=7, serial 0x35 with correct even parity -> rx_data=0x35, rx_parity_err=0; same frame with flipped parity -> rx_parity_err=1.
REQ-025 Stop bit driven 0 on the frame for 0x3C -> entry written with rx_data=0x3C, rx_frame_err=1.
REQ-026 FIFO_DEPTH=4, 5 frames received with rx_ready=0 -> rx_count=4, rx_overrun=1, the first 4 bytes pop in order; ovr_clr then clears the flag.
REQ-027 Push 5 bytes with DEPTH=4 while the first frame is starting -> tx_ready drops at 4 entries, no byte lost or duplicated, frames back-to-back.
REQ-028 rst asserted at mid-data bit 3 of TX and RX -> uart_tx=1 next cycle, counts 0, next transfer correct; a 3-cycle low glitch on uart_rx -> no entry written.
